// File: rtl/mdu_sched.sv
// mdu_sched: 2-entry issue queue that launches MDU operations one at a time.
// Ports: clk/reset, issue_* (E stage), mdu_* (MDU), hilo_rd_ready/sched_busy/pending (stall).
module mdu_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [2:0]  issue_op,
  input  logic [31:0] issue_rs,
  input  logic [31:0] issue_rt,
  output logic        issue_ready,
  output logic        mdu_start,
  output logic [2:0]  mdu_op,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  input  logic        mdu_busy,
  output logic        hilo_rd_ready,
  output logic        sched_busy,
  output logic [1:0]  pending
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT
  } state_t;

  state_t      state;
  logic [2:0]  q_op [2];
  logic [31:0] q_a  [2];
  logic [31:0] q_b  [2];
  logic        wp;
  logic        rp;
  logic [1:0]  count;
  logic        legal;
  logic        push;
  logic        pop;

  assign legal = (issue_op != 3'd0) && (issue_op != 3'd7);

  // Readiness comes from the registered count only: no credit from a pop.
  assign issue_ready   = (count != 2'd2);
  assign push          = issue_valid && issue_ready && legal;
  assign pop           = (state == IDLE) && (count != 2'd0);
  assign hilo_rd_ready = (state == IDLE) && (count == 2'd0);
  assign sched_busy    = !hilo_rd_ready;
  assign pending       = count;

  // Payload storage needs no reset; count/pointers qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      q_op[wp] <= issue_op;
      q_a[wp]  <= issue_rs;
      q_b[wp]  <= issue_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 2'd0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      mdu_start <= 1'b0;
      mdu_op    <= 3'd0;
      mdu_a     <= 32'd0;
      mdu_b     <= 32'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      unique case (1'b1)
        push && !pop: count <= count + 2'd1;
        pop && !push: count <= count - 2'd1;
        default:      count <= count;
      endcase
      mdu_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            mdu_op    <= q_op[rp];
            mdu_a     <= q_a[rp];
            mdu_b     <= q_b[rp];
            mdu_start <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: state <= WAIT;
        WAIT: begin
          if (!mdu_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
